// File: rtl/lfsr8_pkg.sv
// Shared definitions for the 8-bit LFSR generator/checker pair:
// tap mask, checker state encoding and the next-state function.
package lfsr8_pkg;

  localparam logic [7:0] LFSR8_TAPS = 8'h1D;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr8_state_t;

  // Feedback is the XOR of bits 4,3,2,0 shifted in at the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {^(s & LFSR8_TAPS), s[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8_err_acc.sv
// Saturating error accumulator with clear priority over increment.
// With LFSR_CHK_BITERR_EN defined each event adds the bit-error count of diff.
module lfsr8_err_acc
  import lfsr8_pkg::*;
#(
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc_en,
  input  logic [7:0]      diff,
  output logic [ERRW-1:0] cnt
);

  localparam int SW = (ERRW > 4) ? ERRW + 1 : 5;

  logic [3:0]      inc;
  logic [SW-1:0]   sum;
  logic [ERRW-1:0] cnt_reg;
  logic [ERRW-1:0] cnt_next;

`ifdef LFSR_CHK_BITERR_EN
  assign inc = 4'($countones(diff));
`else
  // A counted event always has a non-zero diff, so this is a word count.
  assign inc = (diff != 8'h00) ? 4'd1 : 4'd0;
`endif

  assign sum = SW'(cnt_reg) + SW'(inc);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc_en) begin
      if (sum > SW'({ERRW{1'b1}})) cnt_next = '1;
      else                         cnt_next = sum[ERRW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/lfsr8_checker.sv
// Self-synchronising 8-bit LFSR sequence checker with flywheel lock.
// Optional macro LFSR_CHK_BITERR_EN switches err_cnt to counting bit errors.
module lfsr8_checker
  import lfsr8_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERRW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [7:0]      data,
  input  logic            clr_cnt,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [3:0] LOCK_W   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_W = 4'(UNLOCK_CNT);

  lfsr8_state_t state_reg, state_next;
  logic [7:0]   pred_reg, pred_next;
  logic [3:0]   match_cnt_reg, match_cnt_next;
  logic [3:0]   miss_run_reg, miss_run_next;
  logic         err_reg, err_next;
  logic         count_en;

  always_comb begin
    state_next     = state_reg;
    pred_next      = pred_reg;
    match_cnt_next = match_cnt_reg;
    miss_run_next  = miss_run_reg;
    err_next       = 1'b0;
    count_en       = 1'b0;
    if (valid) begin
      case (state_reg)
        SEARCH: begin
          if (data != 8'h00) begin
            pred_next      = lfsr8_next(data);
            match_cnt_next = '0;
            state_next     = VERIFY;
          end
        end
        VERIFY: begin
          if (data == pred_reg) begin
            pred_next      = lfsr8_next(data);
            match_cnt_next = match_cnt_reg + 4'd1;
            if (match_cnt_next == LOCK_W) state_next = LOCKED;
          end else if (data != 8'h00) begin
            pred_next      = lfsr8_next(data);
            match_cnt_next = '0;
          end else begin
            state_next = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances on its own, data never reseeds it.
          pred_next = lfsr8_next(pred_reg);
          if (data == pred_reg) begin
            miss_run_next = '0;
          end else begin
            err_next      = 1'b1;
            count_en      = 1'b1;
            miss_run_next = miss_run_reg + 4'd1;
            if (miss_run_next == UNLOCK_W) begin
              state_next    = SEARCH;
              miss_run_next = '0;
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SEARCH;
      pred_reg      <= '0;
      match_cnt_reg <= '0;
      miss_run_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pred_reg      <= pred_next;
      match_cnt_reg <= match_cnt_next;
      miss_run_reg  <= miss_run_next;
      err_reg       <= err_next;
    end
  end

  lfsr8_err_acc #(.ERRW(ERRW)) u_err_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_cnt),
    .inc_en (count_en),
    .diff   (data ^ pred_reg),
    .cnt    (err_cnt)
  );

  assign locked = (state_reg == LOCKED);
  assign err    = err_reg;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Scoreboard bench for lfsr8_checker: a behavioural model pushes the expected
// outputs per driven beat, which are popped and compared after the clock edge.
module tb_lfsr8_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int ERRW       = 4;
  localparam int CNT_MAX    = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst, valid, clr_cnt;
  logic [7:0]      data;
  logic            locked, err;
  logic [ERRW-1:0] err_cnt;

  always #5 clk = ~clk;

  lfsr8_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic  lk;
    logic  er;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   beat     = 0;

  // Model state: 0 = search, 1 = verify, 2 = locked
  int         m_state;
  logic [7:0] m_pred;
  int         m_match, m_miss, m_cnt;
  logic       m_err;

  function automatic logic [7:0] ref_next(input logic [7:0] s);
    logic fb;
    fb = s[4] ^ s[3] ^ s[2] ^ s[0];
    return {fb, s[7:1]};
  endfunction

  function automatic int ref_weight(input logic [7:0] x);
    int w;
    w = 0;
`ifdef LFSR_CHK_BITERR_EN
    for (int i = 0; i < 8; i++) w += int'(x[i]);
`else
    w = (x != 8'h00) ? 1 : 0;
`endif
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic c);
    if (r) begin
      m_state = 0; m_pred = 8'h00; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 8'h00) begin m_pred = ref_next(d); m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == m_pred) begin
          m_pred = ref_next(d); m_match++;
          if (m_match == LOCK_CNT) m_state = 2;
        end else if (d != 8'h00) begin
          m_pred = ref_next(d); m_match = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        if (d == m_pred) begin
          m_miss = 0;
        end else begin
          m_err = 1'b1;
          m_cnt = m_cnt + ref_weight(d ^ m_pred);
          if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin m_state = 0; m_miss = 0; end
        end
        m_pred = ref_next(m_pred);
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic drive(input string tag, input logic r, input logic v,
                       input logic [7:0] d, input logic c);
    exp_t e;
    rst = r; valid = v; data = d; clr_cnt = c;
    model_step(r, v, d, c);
    sb.push_back('{m_state == 2, m_err, m_cnt, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    beat++;
    $display("beat %0d %s rst=%0b valid=%0b data=%02h clr=%0b -> locked=%0b err=%0b err_cnt=%0d",
             beat, e.tag, r, v, d, c, locked, err, err_cnt);
    check({e.tag, ".locked"}, 32'(locked), 32'(e.lk));
    check({e.tag, ".err"}, 32'(err), 32'(e.er));
    check({e.tag, ".err_cnt"}, 32'(err_cnt), 32'(e.cnt));
  endtask

  task automatic good(input string tag);
    drive(tag, 1'b0, 1'b1, (m_state == 0) ? 8'h01 : m_pred, 1'b0);
  endtask

  task automatic bad(input string tag, input logic [7:0] mask, input logic c);
    drive(tag, 1'b0, 1'b1, m_pred ^ mask, c);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] mask;
    rst = 1'b1; valid = 1'b0; data = 8'h00; clr_cnt = 1'b0;
    model_step(1'b1, 1'b0, 8'h00, 1'b0);

    drive("reset", 1'b1, 1'b0, 8'h00, 1'b0);
    drive("reset", 1'b1, 1'b1, 8'h55, 1'b0);

    // Acquire lock on the reference sequence
    drive("lock", 1'b0, 1'b1, 8'h01, 1'b0);
    drive("lock", 1'b0, 1'b1, 8'h80, 1'b0);
    drive("lock", 1'b0, 1'b1, 8'h40, 1'b0);
    drive("lock", 1'b0, 1'b1, 8'h20, 1'b0);
    drive("lock", 1'b0, 1'b1, 8'h10, 1'b0);
    check("lock_after_10", 32'(locked), 32'd1);

    // Corrupted 88 -> 89, then the flywheel keeps predicting
    drive("error", 1'b0, 1'b1, 8'h89, 1'b0);
    check("error_pulse", 32'(err), 32'd1);
    drive("idle", 1'b0, 1'b0, 8'h00, 1'b0);
    good("post_err");
    good("post_err");
    good("post_err");

    // Three consecutive misses drop lock
    bad("unlock", 8'h01, 1'b0);
    bad("unlock", 8'h02, 1'b0);
    bad("unlock", 8'h80, 1'b0);
    check("unlocked", 32'(locked), 32'd0);

    // Zero words never seed; zero in verify returns to search
    drive("zero_search", 1'b0, 1'b1, 8'h00, 1'b0);
    drive("zero_search", 1'b0, 1'b1, 8'h00, 1'b0);
    drive("zero_search", 1'b0, 1'b1, 8'h00, 1'b0);
    drive("seed", 1'b0, 1'b1, 8'h05, 1'b0);
    drive("zero_verify", 1'b0, 1'b1, 8'h00, 1'b0);
    s = ref_next(8'h05);
    for (int i = 0; i < LOCK_CNT + 1; i++) begin
      drive("relock", 1'b0, 1'b1, s, 1'b0);
      s = ref_next(s);
    end

    // Saturation: alternate miss/match so lock holds
    bad("sat_ff", 8'hFF, 1'b0);
    good("sat_good");
    for (int i = 0; i < 20; i++) begin
      bad("sat", 8'h01, 1'b0);
      good("sat_good");
    end
    check("saturated", 32'(err_cnt), 32'(CNT_MAX));

    // Clear beats a simultaneous counted error; err still pulses
    bad("clr_err", 8'h10, 1'b1);
    good("after_clr");
    drive("clr_idle", 1'b0, 1'b0, 8'h00, 1'b1);

    // Build err_cnt=5, then reset mid-lock
    for (int i = 0; i < 5; i++) begin
      bad("five", 8'h04, 1'b0);
      good("five_good");
    end
    drive("rst_mid", 1'b1, 1'b1, m_pred, 1'b0);
    check("rst_mid_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < LOCK_CNT + 1; i++) good("relock_rst");
    check("relocked", 32'(locked), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        drive("rnd_idle", 1'b0, 1'b0, 8'($urandom), ($urandom_range(0, 9) == 0));
      end else if ($urandom_range(0, 4) == 0) begin
        mask = 8'($urandom_range(1, 255));
        bad("rnd_bad", mask, ($urandom_range(0, 9) == 0));
      end else if ($urandom_range(0, 15) == 0) begin
        drive("rnd_zero", 1'b0, 1'b1, 8'h00, 1'b0);
      end else begin
        good("rnd_good");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
